// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Gshare conditional-branch direction predictor.
//
// A table of 2^IDX_BITS two-bit saturating counters is looked up in fetch. The
// table index is the word-aligned PC slice XOR-ed with a global history of
// resolved branch outcomes. The counter MSB is the predicted direction. Execute
// trains the table with the resolved outcome. It also shifts the outcome into
// the global history, which is non-speculative and only moves at resolve time.
// Execute raises a registered one-cycle mispredict pulse for the pipeline flush
// logic and maintains two saturating performance counters.
//
// Parameters
//   IDX_BITS        log2 of table entries; the index uses pred_pc[IDX_BITS+1:2]
//   HIST_BITS       global history length, legal range 1..IDX_BITS
//
// Ports
//   clk             clock; all state changes on the rising edge
//   rst             asynchronous reset, active-high
//   pred_pc         fetch PC to predict
//   pred_taken      predicted direction (counter MSB), combinational
//   pred_idx        table index used for this lookup; carried down to EX
//   upd_valid       EX holds a resolved conditional branch this cycle
//   upd_idx         pred_idx captured at fetch for the resolving branch
//   upd_taken       resolved outcome
//   upd_pred_taken  direction that was predicted at fetch
//   mispredict      registered pulse, the cycle after a wrong resolve
//   num_branches    resolved branch count (saturating)
//   num_mispredicts mispredicted branch count (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_BITS  = 6,
  parameter int HIST_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  input  logic                upd_pred_taken,
  output logic                mispredict,
  output logic [31:0]         num_branches,
  output logic [31:0]         num_mispredicts
);

  localparam int          ENTRIES   = 1 << IDX_BITS;
  localparam logic [1:0]  CTR_RESET = 2'b01;          // weakly not-taken
  localparam logic [1:0]  CTR_MAX   = 2'b11;
  localparam logic [1:0]  CTR_MIN   = 2'b00;
  localparam logic [31:0] STAT_MAX  = 32'hFFFF_FFFF;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr,
                                            input logic       taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) res = ctr + 2'd1;
    end else begin
      if (ctr != CTR_MIN) res = ctr - 2'd1;
    end
    return res;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] stat_inc(input logic [31:0] cnt);
    logic [31:0] res;
    res = (cnt == STAT_MAX) ? cnt : cnt + 32'd1;
    return res;
  endfunction

  // State
  logic [1:0]           tbl_q [ENTRIES];
  logic [1:0]           tbl_entry_d;
  logic [HIST_BITS-1:0] ghr_q;
  logic [HIST_BITS-1:0] ghr_d;
  logic [HIST_BITS-1:0] ghr_shift;
  logic                 mispredict_q;
  logic                 mispredict_d;
  logic [31:0]          nbr_q;
  logic [31:0]          nbr_d;
  logic [31:0]          nmis_q;
  logic [31:0]          nmis_d;
  logic                 upd_wrong;

  // PC bits outside the index slice do not take part in the prediction.
  logic                 unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

  // Lookup: the history is zero-extended into the low index bits, so a short
  // history only perturbs the low end of the PC slice.
  logic [IDX_BITS-1:0]  ghr_ext;
  assign ghr_ext    = IDX_BITS'(ghr_q);
  assign pred_idx   = pred_pc[IDX_BITS+1:2] ^ ghr_ext;
  // Pure read of registered state: an update landing on the same entry this
  // cycle becomes visible only after the edge (no bypass).
  assign pred_taken = tbl_q[pred_idx][1];

  // Shift the newest resolved outcome into the history LSB.
  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_shift = upd_taken;
    end else begin : g_histn
      assign ghr_shift = {ghr_q[HIST_BITS-2:0], upd_taken};
    end
  endgenerate

  assign upd_wrong   = upd_taken ^ upd_pred_taken;
  assign tbl_entry_d = ctr_update(tbl_q[upd_idx], upd_taken);

  always_comb begin
    ghr_d        = ghr_q;
    nbr_d        = nbr_q;
    nmis_d       = nmis_q;
    // The pulse is recomputed every cycle, so it drops when nothing resolves.
    mispredict_d = upd_valid & upd_wrong;
    if (upd_valid) begin
      ghr_d = ghr_shift;
      nbr_d = stat_inc(nbr_q);
      if (upd_wrong) begin
        nmis_d = stat_inc(nmis_q);
      end
    end
  end

  // Reset wins over any update presented on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= CTR_RESET;
      end
      ghr_q        <= '0;
      mispredict_q <= 1'b0;
      nbr_q        <= '0;
      nmis_q       <= '0;
    end else begin
      if (upd_valid) begin
        tbl_q[upd_idx] <= tbl_entry_d;
      end
      ghr_q        <= ghr_d;
      mispredict_q <= mispredict_d;
      nbr_q        <= nbr_d;
      nmis_q       <= nmis_d;
    end
  end

  assign mispredict      = mispredict_q;
  assign num_branches    = nbr_q;
  assign num_mispredicts = nmis_q;

endmodule
